// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive path with 3-sample majority voting per bit.
// Ports:
//   clk_50m   system clock
//   rst_n     asynchronous active-low reset
//   rx        serial line, idle high, asynchronous to clk_50m
//   clken     oversample tick, one clk_50m cycle wide, OVERSAMPLE x baud
//   rdy_clr   consumer acknowledge, clears rdy/frame_err/overrun
//   dout      last received byte
//   rdy       byte available, sticky until rdy_clr
//   frame_err stop bit of the byte in dout sampled low
//   overrun   a byte completed while rdy was already set
//   rx_busy   receiver is inside a frame
module uart_receiver #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       clken,
  input  logic       rdy_clr,
  output logic [7:0] dout,
  output logic       rdy,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);
  localparam int M  = OVERSAMPLE / 2;
  localparam int SW = $clog2(OVERSAMPLE);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic [SW-1:0]          s, s_n;
  logic [3:0]             b, b_n;
  logic [1:0]             v, v_n;
  logic [7:0]             sh, sh_n;
  logic                   maj, dec, wrap, done;

  assign rx_s    = sync[SYNC_STAGES-1];
  assign maj     = (v[0] & v[1]) | (v[0] & rx_s) | (v[1] & rx_s);
  assign dec     = clken && (s == SW'(M + 1));
  assign wrap    = s == SW'(OVERSAMPLE - 1);
  assign rx_busy = state != IDLE;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '1;
      state <= IDLE;
      s     <= '0;
      b     <= '0;
      v     <= '0;
      sh    <= '0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], rx};
      state <= state_n;
      s     <= s_n;
      b     <= b_n;
      v     <= v_n;
      sh    <= sh_n;
    end
  end

  // The detecting tick is sample 0 of the start bit, so the counter resumes at 1.
  always_comb begin
    state_n = state;
    s_n     = s;
    b_n     = b;
    v_n     = v;
    sh_n    = sh;
    done    = 1'b0;
    if (clken) begin
      s_n = wrap ? '0 : s + 1'b1;
      b_n = wrap ? b + 4'd1 : b;
      if (s == SW'(M - 1)) v_n[0] = rx_s;
      if (s == SW'(M)) v_n[1] = rx_s;
      case (state)
        IDLE: begin
          state_n = rx_s ? IDLE : START;
          s_n     = rx_s ? '0 : SW'(1);
          b_n     = '0;
        end
        START: if (dec) state_n = maj ? IDLE : DATA;
        DATA: if (dec) begin
          sh_n    = {maj, sh[7:1]};
          state_n = (b == 4'd8) ? STOP : DATA;
        end
        STOP: if (dec) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      endcase
    end
  end

  // Completion takes priority over a simultaneous rdy_clr.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      dout      <= '0;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (done) begin
      dout      <= sh;
      rdy       <= 1'b1;
      frame_err <= ~maj;
      overrun   <= ~rdy_clr & (rdy | overrun);
    end else if (rdy_clr) begin
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench for uart_receiver, clken every 4th clk_50m cycle.
module tb_uart_receiver;
  logic       clk_50m = 1'b0;
  logic       rst_n   = 1'b0;
  logic       rx      = 1'b1;
  logic       clken   = 1'b0;
  logic       rdy_clr = 1'b0;
  logic [7:0] dout;
  logic       rdy, frame_err, overrun, rx_busy;
  logic [1:0] cnt = 2'd0;
  int         total = 0;
  int         bad   = 0;
  logic       rdy_m = 1'b0;
  logic       ov_m  = 1'b0;

  typedef struct {logic [7:0] d; logic fe; logic ov;} exp_t;
  exp_t sb[$];

  uart_receiver dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .rx(rx), .clken(clken), .rdy_clr(rdy_clr),
    .dout(dout), .rdy(rdy), .frame_err(frame_err), .overrun(overrun), .rx_busy(rx_busy)
  );

  always #10 clk_50m = ~clk_50m;

  // clken changes on the falling edge so it is stable at every rising edge.
  always @(negedge clk_50m) begin
    cnt   <= cnt + 2'd1;
    clken <= cnt == 2'd3;
  end

  task automatic wait_tick;
    do @(posedge clk_50m); while (!clken);
    #1;
  endtask

  task automatic pulse_clr;
    @(negedge clk_50m);
    rdy_clr = 1'b1;
    @(posedge clk_50m);
    #1;
    rdy_clr = 1'b0;
    total++;
    if (rdy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL clr: rdy/fe/ov got %b%b%b expected 000", rdy, frame_err, overrun);
    end
    rdy_m = 1'b0;
    ov_m  = 1'b0;
  endtask

  // Drives one frame tick by tick; rx for tick k is set just after tick k-1.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic clr_end,
                            input int glitch_k, input int abort_k);
    exp_t       e;
    logic [9:0] fr;
    fr   = {stop, d, 1'b0};
    e.d  = d;
    e.fe = ~stop;
    e.ov = clr_end ? 1'b0 : (ov_m | rdy_m);
    if (abort_k < 0) sb.push_back(e);
    for (int k = 0; k < 160; k++) begin
      rx = (k >= 154) ? 1'b1 : fr[k/16] ^ (k == glitch_k);
      if (k == 153 && clr_end) begin
        do begin @(negedge clk_50m); #1; end while (!clken);
        rdy_clr = 1'b1;
      end
      wait_tick;
      rdy_clr = 1'b0;
      if (k == abort_k) begin
        rst_n = 1'b0;
        #1;
        total++;
        if ({dout, rdy, frame_err, overrun, rx_busy} !== 12'h000) begin
          bad++;
          $display("FAIL abort_reset: dout=%h rdy=%b fe=%b ov=%b busy=%b expected all 0",
                   dout, rdy, frame_err, overrun, rx_busy);
        end
        @(negedge clk_50m);
        rst_n = 1'b1;
        rx    = 1'b1;
        rdy_m = 1'b0;
        ov_m  = 1'b0;
        return;
      end
      if (k == 0 || k == 152) begin
        total++;
        if (rx_busy !== 1'b1) begin
          bad++;
          $display("FAIL busy_k%0d: got %b expected 1", k, rx_busy);
        end
      end
      if (k == 152) begin
        total++;
        if (rdy !== rdy_m) begin
          bad++;
          $display("FAIL rdy_early: got %b expected %b", rdy, rdy_m);
        end
      end
      if (k == 153) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL scoreboard: empty at completion");
        end else begin
          e = sb.pop_front();
          if (dout !== e.d || rdy !== 1'b1 || frame_err !== e.fe || overrun !== e.ov ||
              rx_busy !== 1'b0) begin
            bad++;
            $display("FAIL frame_%h: dout=%h rdy=%b fe=%b ov=%b busy=%b expected %h 1 %b %b 0",
                     e.d, dout, rdy, frame_err, overrun, rx_busy, e.d, e.fe, e.ov);
          end
          rdy_m = 1'b1;
          ov_m  = e.ov;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    total++;
    if ({dout, rdy, frame_err, overrun, rx_busy} !== 12'h000) begin
      bad++;
      $display("FAIL reset: dout=%h rdy=%b fe=%b ov=%b busy=%b expected all 0",
               dout, rdy, frame_err, overrun, rx_busy);
    end
    repeat (5) @(negedge clk_50m);
    rst_n = 1'b1;
    repeat (20) wait_tick;
    total++;
    if (rx_busy !== 1'b0 || rdy !== 1'b0) begin
      bad++;
      $display("FAIL idle: busy=%b rdy=%b expected 0 0", rx_busy, rdy);
    end
  endtask

  task automatic test_clean;
    send_frame(8'h55, 1'b1, 1'b0, -1, -1);
  endtask

  task automatic test_glitch_start;
    pulse_clr;
    for (int k = 0; k < 16; k++) begin
      rx = k >= 4;
      wait_tick;
      if (k == 8 || k == 9) begin
        total++;
        if (rx_busy !== (k == 8)) begin
          bad++;
          $display("FAIL glitch_busy_k%0d: got %b expected %b", k, rx_busy, k == 8);
        end
      end
    end
    total++;
    if (rdy !== 1'b0 || dout !== 8'h55) begin
      bad++;
      $display("FAIL glitch_start: rdy=%b dout=%h expected 0 55", rdy, dout);
    end
  endtask

  task automatic test_frame_err;
    send_frame(8'hA3, 1'b0, 1'b0, -1, -1);
    pulse_clr;
  endtask

  task automatic test_back_to_back;
    send_frame(8'h12, 1'b1, 1'b0, -1, -1);
    send_frame(8'h34, 1'b1, 1'b0, -1, -1);
    send_frame(8'h7E, 1'b1, 1'b1, -1, -1);
  endtask

  task automatic test_vote;
    send_frame(8'h00, 1'b1, 1'b0, 3 * 16 + 8, -1);
  endtask

  task automatic test_abort;
    send_frame(8'hFF, 1'b1, 1'b0, -1, 4 * 16 + 5);
    repeat (3) wait_tick;
    send_frame(8'hC6, 1'b1, 1'b0, -1, -1);
  endtask

  initial begin
    test_reset;
    test_clean;
    test_glitch_start;
    test_frame_err;
    test_back_to_back;
    test_vote;
    test_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
UART receive path; mirror of the existing transmitter. 8N1 frames, LSB first.
Samples the asynchronous rx line on a shared oversampling enable (clken = 16x baud, one clk_50m cycle wide, from the baud generator) and uses 3-sample majority voting per bit.
Presents each received byte with a ready/clear handshake plus framing-error and overrun flags.

Parameters:
OVERSAMPLE, 16, clken ticks per bit; even, >= 8; mid-point M = OVERSAMPLE/2
SYNC_STAGES, 2, flip-flop stages on rx before use; >= 2

Ports:
clk_50m  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx  input  1  serial line, idle high, asynchronous to clk_50m
clken  input  1  oversample tick, single-cycle pulse, OVERSAMPLE x baud
rdy_clr  input  1  consumer acknowledge; clears rdy/frame_err/overrun
dout  output  8  last received byte
rdy  output  1  byte available, sticky until rdy_clr
frame_err  output  1  stop bit of byte in dout sampled low
overrun  output  1  byte completed while rdy already set
rx_busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; dout=8'h00; rdy=0; frame_err=0; overrun=0; sync chain all 1; counters 0. Reset mid-frame aborts the frame; no partial byte reaches dout.
- rx passes through SYNC_STAGES flops (rx_s); all decisions use rx_s only.
- State, counters and sampling advance only on cycles with clken=1. Handshake outputs update on any clk_50m edge.
- Sample counter s runs 0..OVERSAMPLE-1 per bit, wraps to 0 and advances the bit index. Bit index: 0 = start, 1..8 = data, 9 = stop.
- Votes are taken at s = M-1, M, M+1; the bit value is the majority of the three; the decision is made at s = M+1.
- IDLE: on the first clken with rx_s=0, go to START with s=0 (this tick = t0).
- START: at the decision, majority 1 -> glitch, return to IDLE with no flags; majority 0 -> continue into DATA.
- DATA: each decision shifts the bit into the shift register LSB first (bit 1 -> dout[0]). After bit 8, go to STOP.
- STOP: at the decision tick t0 + 9*OVERSAMPLE + M + 1 (153 for default):
  - dout <= shift register; rdy <= 1
  - frame_err <= ~majority
  - overrun <= 1 if rdy was already 1 and rdy_clr is not asserted this cycle
  - state -> IDLE immediately (mid-stop), so a following start edge is accepted.
- rdy_clr: clears rdy, frame_err and overrun on the next edge.
  - rdy_clr in the same cycle as byte completion: completion wins (rdy=1, frame_err from the new byte, overrun=0).
- Overrun: the new byte overwrites dout; overrun stays sticky until rdy_clr.
- rx_busy is combinational from state; it falls at the STOP decision or on glitch rejection.
- No clken pulses: the FSM freezes; the handshake still works.

Test Plan:
Bench uses clken every 4th clk_50m cycle and OVERSAMPLE=16.
1. Clean frame 0x55 -> dout=0x55, rdy=1, frame_err=0, overrun=0. rdy rises on tick t0+153; rx_busy high from t0 to that tick.
2. rx low for 4 ticks then high -> returns to IDLE at s=9 of START; rdy stays 0; dout unchanged.
3. Frame 0xA3 with stop bit driven 0 -> dout=0xA3, rdy=1, frame_err=1. Pulse rdy_clr -> rdy=0, frame_err=0 next cycle.
4. Frames 0x12 then 0x34 back-to-back, no rdy_clr -> dout=0x34, rdy=1, overrun=1. Then 0x7E with rdy_clr asserted on its completion cycle -> dout=0x7E, rdy=1, overrun=0.
5. Frame 0x00 with rx inverted for a single tick at s=8 of data bit 3 -> dout=0x00, frame_err=0 (majority vote).
6. rst_n pulsed low during data bit 4 of 0xFF -> all outputs at reset values immediately, rx_busy=0. A following clean 0xC6 -> dout=0xC6, rdy=1.
